uart_rx: RTL

- UART receiver. Consumes the serial line driven by the link partner's transmitter.
- Uses the same FREQ/BAUD_RATE timing as the baud generator, but runs its own bit-period counter so it can resynchronise on every start bit and sample at mid-bit.
- Frame format: 8N1, LSB first.
- Delivers each received byte on a valid/ready handshake and flags framing errors and overruns.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver, DATA_BITS-N-1, LSB first. A private bit-period counter resynchronises
// on every start bit and samples mid-bit; bytes are delivered on a valid/ready handshake.
module uart_rx #(
    parameter int unsigned FREQ      = 1000000,
    parameter int unsigned BAUD_RATE = 2400,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned CLKS_PER_BIT = FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx: FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic [1:0]           sync_q;
    logic                 rx_s;

    // Two-flop synchroniser; the line idles high.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        // Acceptance is resolved before a completing frame decides load vs. overrun.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        if (!valid_d) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign busy        = busy_q;
    assign frame_err   = fe_q;
    assign overrun_err = ov_q;

endmodule
